instr_encoder: RTL and testbench

Inverse of the main control decoder. It accepts symbolic instruction requests (op class, register fields, immediate) over a valid/ready handshake and encodes them into 32-bit MIPS words. Encoded words are buffered in a FIFO and emitted with a sequential word address, so a bench or boot loader can fill instruction memory for the single-cycle and pipelined cores. It covers exactly the instruction subset the control decoder supports.

---
 rtl/instr_pkg.sv | 68 ++++++
 rtl/sync_fifo.sv | 50 +++++
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: op enum, opcodes, functs, field layout.
// Used by the instruction encoder, control decoder and ALU control.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_ANDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9,
        OP_BNE  = 4'd10,
        OP_J    = 4'd11
    } op_e;

    localparam int INSTR_W = 32;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [INSTR_W-1:0] enc_r(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd,
        input logic [5:0]       funct
    );
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [INSTR_W-1:0] enc_i(
        input logic [5:0]       opc,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [IMM_W-1:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [INSTR_W-1:0] enc_j(
        input logic [TGT_W-1:0] tgt
    );
        return {OPC_J, tgt};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is presented combinationally.
import instr_pkg::*;

module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic requests into MIPS words, queued with sequential addresses.
// Optional ENC_RANGE_CHECK_EN rejects I-type immediates that do not fit 16 bits.
import instr_pkg::*;

module instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [4:0]              in_rs,
    input  logic [4:0]              in_rt,
    input  logic [4:0]              in_rd,
    input  logic [25:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    err,
    output logic [$clog2(DEPTH):0]  count
);

`ifdef ENC_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    logic [31:0] word;
    logic        legal;
    logic        itype;
    logic        imm_bad;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        itype = 1'b0;
        case (in_op)
            OP_ADD:  word = enc_r(in_rs, in_rt, in_rd, FN_ADD);
            OP_SUB:  word = enc_r(in_rs, in_rt, in_rd, FN_SUB);
            OP_AND:  word = enc_r(in_rs, in_rt, in_rd, FN_AND);
            OP_OR:   word = enc_r(in_rs, in_rt, in_rd, FN_OR);
            OP_SLT:  word = enc_r(in_rs, in_rt, in_rd, FN_SLT);
            OP_ADDI: begin
                word  = enc_i(OPC_ADDI, in_rs, in_rt, in_imm[15:0]);
                itype = 1'b1;
            end
            OP_ANDI: begin
                word  = enc_i(OPC_ANDI, in_rs, in_rt, in_imm[15:0]);
                itype = 1'b1;
            end
            OP_LW: begin
                word  = enc_i(OPC_LW, in_rs, in_rt, in_imm[15:0]);
                itype = 1'b1;
            end
            OP_SW: begin
                word  = enc_i(OPC_SW, in_rs, in_rt, in_imm[15:0]);
                itype = 1'b1;
            end
            OP_BEQ: begin
                word  = enc_i(OPC_BEQ, in_rs, in_rt, in_imm[15:0]);
                itype = 1'b1;
            end
            OP_BNE: begin
                word  = enc_i(OPC_BNE, in_rs, in_rt, in_imm[15:0]);
                itype = 1'b1;
            end
            OP_J:    word  = enc_j(in_imm);
            default: legal = 1'b0;
        endcase
    end

    // Upper immediate bits must be a sign extension of bit 15.
    assign imm_bad = RANGE_CHECK && itype &&
                     (in_imm[25:16] != {10{in_imm[15]}});

    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal && !imm_bad;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            out_addr <= ADDR_W'(BASE_ADDR);
        end else begin
            err <= accept && !(legal && !imm_bad);
            if (pop) out_addr <= out_addr + ADDR_W'(1);
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (out_instr),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, err, wrap, reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [25:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err;
    logic [2:0]  count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_instr;
    logic [1:0]  s_out_addr;
    logic        s_err;
    logic [2:0]  s_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .count(count)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_instr(s_out_instr), .out_addr(s_out_addr),
        .err(s_err), .count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [25:0] imm);
        int n;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] instr,
                              input logic [7:0] addr);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"}, 32'(out_addr), 32'(addr));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [1:0] exp2 [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_imm    = '0;
        out_ready = 1'b0;

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);

        // ADD with unused imm set; one cycle latency
        out_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_instr", out_instr, 32'h00221820);
        check("add_addr", 32'(out_addr), 32'd0);
        check("add_count", 32'(count), 32'd1);
        tick();
        check("add_popped", 32'(out_valid), 32'd0);
        check("add_cnt0", 32'(count), 32'd0);
        check("add_addr1", 32'(out_addr), 32'd1);
        out_ready = 1'b0;

        // LW, BNE, J in order
        do_reset();
        send(4'd7, 5'd9, 5'd8, 5'd0, 26'h0000004);
        send(4'd10, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF);
        send(4'd11, 5'd31, 5'd31, 5'd31, 26'h0000100);
        check("seq_count", 32'(count), 32'd3);
        expect_pop("lw", 32'h8D280004, 8'd0);
        expect_pop("bne", 32'h1422FFFF, 8'd1);
        expect_pop("j", 32'h08000100, 8'd2);
        check("seq_empty", 32'(count), 32'd0);

        // backpressure: 5 requests into a 4-deep FIFO
        do_reset();
        send(4'd1, 5'd1, 5'd1, 5'd1, 26'd0);
        send(4'd2, 5'd2, 5'd2, 5'd2, 26'd0);
        send(4'd3, 5'd3, 5'd3, 5'd3, 26'd0);
        send(4'd4, 5'd4, 5'd4, 5'd4, 26'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        in_op    = 4'd0;
        in_rs    = 5'd5;
        in_rt    = 5'd5;
        in_rd    = 5'd5;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        check("stall_count", 32'(count), 32'd4);
        check("stall_ready", 32'(in_ready), 32'd0);
        expect_pop("sub", 32'h00210822, 8'd0);
        check("free_ready", 32'(in_ready), 32'd1);
        check("free_count", 32'(count), 32'd3);
        tick();
        in_valid = 1'b0;
        check("refill_count", 32'(count), 32'd4);
        expect_pop("and", 32'h00421024, 8'd1);
        expect_pop("or", 32'h00631825, 8'd2);
        expect_pop("slt", 32'h0084202A, 8'd3);
        expect_pop("add5", 32'h00A52820, 8'd4);
        check("drain_valid", 32'(out_valid), 32'd0);

        // illegal op: err pulse, nothing queued
        do_reset();
        send(4'd13, 5'd1, 5'd2, 5'd3, 26'd7);
        check("ill_err", 32'(err), 32'd1);
        check("ill_count", 32'(count), 32'd0);
        check("ill_valid", 32'(out_valid), 32'd0);
        tick();
        check("ill_err_low", 32'(err), 32'd0);
        send(4'd8, 5'd29, 5'd31, 5'd0, 26'h000FFFC);
        check("sw_err", 32'(err), 32'd0);
        send(4'd6, 5'd3, 5'd4, 5'd0, 26'h00000FF);
        send(4'd9, 5'd5, 5'd6, 5'd0, 26'h3FFFFFE);
        expect_pop("sw", 32'hAFBFFFFC, 8'd0);
        expect_pop("andi", 32'h306400FF, 8'd1);
        expect_pop("beq", 32'h10A6FFFE, 8'd2);

        // ADDR_W=2 wrap on the second instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(4'd11, 5'd0, 5'd0, 5'd0, 26'(i));
            check("w2_valid", 32'(s_out_valid), 32'd1);
            check("w2_instr", s_out_instr, 32'h08000000 | 32'(i));
            check("w2_addr", 32'(s_out_addr), 32'(exp2[i]));
            check("w8_addr", 32'(out_addr), 32'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // reset with words queued
        do_reset();
        send(4'd0, 5'd1, 5'd1, 5'd1, 26'd0);
        send(4'd0, 5'd2, 5'd2, 5'd2, 26'd0);
        send(4'd0, 5'd3, 5'd3, 5'd3, 26'd0);
        check("q3_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("q3_addr1", 32'(out_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_addr", 32'(out_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(4'd11, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
        expect_pop("post_rst", 32'h0BFFFFFF, 8'd0);

        // immediate range
        do_reset();
        send(4'd5, 5'd2, 5'd3, 5'd0, 26'h3FF8000);
        check("addi_ok_err", 32'(err), 32'd0);
        expect_pop("addi_ok", 32'h20438000, 8'd0);
        send(4'd5, 5'd0, 5'd0, 5'd0, 26'h0010000);
`ifdef ENC_RANGE_CHECK_EN
        check("range_err", 32'(err), 32'd1);
        check("range_count", 32'(count), 32'd0);
        check("range_valid", 32'(out_valid), 32'd0);
`else
        check("trunc_err", 32'(err), 32'd0);
        expect_pop("trunc", 32'h20000000, 8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
